// File: rtl/pilots_remove.sv
// pilots_remove: RX pilot/null remover between the FFT and the QAM64 demapper.
// Accepts one 64-bin FFT symbol in natural bin order, drops DC and null bins,
// captures the four pilots on a side port and emits the 48 data carriers in
// subcarrier order -26..+26 (bins 38..63 first, then buffered bins 1..26).
module pilots_remove #(
  parameter int IQ_W = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [2*IQ_W-1:0]   DAT_I,
  input  logic                CYC_I,
  input  logic                WE_I,
  input  logic                STB_I,
  output logic                ACK_O,
  output logic [2*IQ_W-1:0]   DAT_O,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
  input  logic                ACK_I,
  output logic [8*IQ_W-1:0]   PLT_O,
  output logic                PLT_VLD_O
);

  localparam int SW = 2 * IQ_W;

  // Symbol phase, decoded from the bin counter plus the drain flag.
  typedef enum logic [1:0] {
    FILL,    // bins 0..26: positive carriers go to the buffer
    SKIP,    // bins 27..37: upper/lower nulls
    STREAM,  // bins 38..63: negative carriers go straight out
    DRAIN    // buffered positive carriers go out
  } phase_t;

  logic [5:0]    k;          // bin index of the next input sample
  logic          draining;
  logic [4:0]    rd_ptr;     // next buffer word to emit while draining
  logic [4:0]    wr_addr;    // buffer slot for the current FILL bin
  logic [SW-1:0] buffer [24];

  // Pilot shadow registers, named by subcarrier index
  logic [SW-1:0] plt_m21, plt_m7, plt_p7, plt_p21;

  phase_t phase;
  logic   is_pilot;
  logic   can_load;
  logic   in_beat;
  logic   buf_wr;
  logic   str_load;
  logic   drn_load;
  logic   abort;
  logic   last_bin;

  // Phase decode from bin counter and drain flag.
  always_comb begin
    phase = FILL;
    if (draining)         phase = DRAIN;
    else if (k <= 6'd26)  phase = FILL;
    else if (k <= 6'd37)  phase = SKIP;
    else                  phase = STREAM;
  end

  // Handshake and datapath control for the current cycle.
  always_comb begin
    is_pilot = (k == 6'd7) || (k == 6'd21) || (k == 6'd43) || (k == 6'd57);
    // The output register can take a new word when empty or being drained.
    can_load = !STB_O || ACK_I;
    ACK_O    = 1'b0;
    if (!RST_I) begin
      unique case (phase)
        FILL, SKIP: ACK_O = 1'b1;
        STREAM:     ACK_O = is_pilot ? 1'b1 : can_load;
        DRAIN:      ACK_O = 1'b0;
        default:    ACK_O = 1'b0;
      endcase
    end
    in_beat  = CYC_I && STB_I && WE_I && ACK_O;
    buf_wr   = in_beat && (phase == FILL) && (k != 6'd0) && !is_pilot;
    str_load = in_beat && (phase == STREAM) && !is_pilot;
    drn_load = (phase == DRAIN) && can_load;
    abort    = !CYC_I && (k != 6'd0) && !draining;
    last_bin = in_beat && (k == 6'd63);
    // Bins 1..26 minus pilots 7 and 21 pack densely into slots 0..23.
    wr_addr  = 5'(k - 6'd1 - {5'd0, k > 6'd7} - {5'd0, k > 6'd21});
  end

  // Bin counter, drain flag and drain read pointer.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      k        <= '0;
      draining <= 1'b0;
      rd_ptr   <= '0;
    end else begin
      if (abort)        k <= '0;
      else if (in_beat) k <= k + 6'd1;   // wraps 63 -> 0

      if (last_bin)                          draining <= 1'b1;
      else if (drn_load && rd_ptr == 5'd23)  draining <= 1'b0;

      if (drn_load) rd_ptr <= (rd_ptr == 5'd23) ? 5'd0 : rd_ptr + 5'd1;
    end
  end

  // Positive-carrier buffer write.
  // NOTE: the buffer is deliberately not reset; every slot is rewritten during
  // FILL before DRAIN reads it, so a reset would only cost routing.
  always_ff @(posedge CLK_I) begin
    if (buf_wr) buffer[wr_addr] <= DAT_I;
  end

  // Capture pilots into shadow registers as their bins arrive.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      plt_m21 <= '0;
      plt_m7  <= '0;
      plt_p7  <= '0;
      plt_p21 <= '0;
    end else if (in_beat) begin
      case (k)
        6'd7:    plt_p7  <= DAT_I;
        6'd21:   plt_p21 <= DAT_I;
        6'd43:   plt_m21 <= DAT_I;
        6'd57:   plt_m7  <= DAT_I;
        default: ;
      endcase
    end
  end

  // Output register: load from the stream or the buffer, hold until accepted.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      DAT_O <= '0;
      STB_O <= 1'b0;
    end else if (str_load) begin
      DAT_O <= DAT_I;
      STB_O <= 1'b1;
    end else if (drn_load) begin
      DAT_O <= buffer[rd_ptr];
      STB_O <= 1'b1;
    end else if (STB_O && ACK_I) begin
      STB_O <= 1'b0;
    end
  end

  // Publish all four pilots together once a full symbol has been accepted.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      PLT_O     <= '0;
      PLT_VLD_O <= 1'b0;
    end else begin
      PLT_VLD_O <= last_bin;
      if (last_bin) PLT_O <= {plt_m21, plt_m7, plt_p7, plt_p21};
    end
  end

  // Output cycle: opens on any input beat, closes once fully idle.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      CYC_O <= 1'b0;
    end else if (in_beat) begin
      CYC_O <= 1'b1;
    end else if (!CYC_I && (k == 6'd0) && !draining && !STB_O) begin
      CYC_O <= 1'b0;
    end
  end

  assign WE_O = STB_O;

endmodule
